clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_ctrl.sv | 85 ++++++++
 tb/tb_clk_gate_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: glitch-free clock gate built from a low-phase transparent enable
// latch and an AND gate. It adds a scan override and reset qualification.
//
// Optional feature: define CLK_GATE_CNT_EN to add a saturating counter of gated
// clk_o rising edges (cnt_o). When the macro is undefined, cnt_o is tied to zero
// and clr_cnt_i is ignored.
//
// Parameters:
//   CntWidth  - width of cnt_o (1..32)
//   ResetGate - 1: clk_o is held low during reset unless test_en_i is high.
//               0: reset only clears the enable latch.
module clk_gate_ctrl #(
  parameter int CntWidth  = 16,
  parameter int ResetGate = 1
) (
  input  logic                clk_int,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                test_en_i,
  input  logic                clr_cnt_i,
  output logic                clk_o,
  output logic                en_latched_o,
  output logic [CntWidth-1:0] cnt_o
);

  // Enable latch state and reset qualification terms.
  logic en_l;
  logic latch_clr;
  logic rst_ok;

  // With ResetGate set, scan mode overrides reset. The latch must then stay
  // transparent so that test_en_i can push the clock through.
  assign latch_clr = (ResetGate != 0) ? (~rst_ni & ~test_en_i) : ~rst_ni;

  // Reset only gates clk_o directly when ResetGate is set. In that case
  // asserting reset pulls clk_o low at once, even in the middle of a high phase.
  assign rst_ok = (ResetGate != 0) ? (rst_ni | test_en_i) : 1'b1;

  // Enable latch: transparent while clk_int is low, holds while it is high.
  // Because the latch is closed for the whole high phase, enable changes made
  // during a high phase cannot cut or stretch a clk_o pulse. When reset is
  // released in the middle of a high phase, the latch keeps 0 until the next
  // low phase, so no partial pulse can appear.
  always_latch begin
    if (latch_clr) begin
      en_l <= 1'b0;
    end else if (!clk_int) begin
      en_l <= en_i | test_en_i;
    end
  end

  assign en_latched_o = en_l;

  // Gated clock output.
  assign clk_o = clk_int & en_l & rst_ok;

`ifdef CLK_GATE_CNT_EN
  // All-ones value at which the counter stops.
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  logic [CntWidth-1:0] cnt_q;

  // Activity counter, clocked by the ungated clk_int. It advances on every edge
  // where the gate is open. A clear wins over an increment on the same edge,
  // and the counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (en_l && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`else
  // No counter in this build: the output is constant and the clear input is
  // accepted but has no effect.
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt_i;
  assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed bench for clk_gate_ctrl.
// dut_a uses ResetGate=1 and CntWidth=16; dut_b uses ResetGate=0 and CntWidth=3.
// Inputs change 1 ns after a clock edge. Outputs are sampled 2 ns into a phase,
// or at fixed offsets inside a high phase for the glitch and reset-edge cases.
module tb_clk_gate_ctrl;

  // ---------------- clock / reset ----------------
  logic clk_int = 1'b0;
  logic rst_ni;
  logic en_i;
  logic test_en_i;
  logic clr_cnt_i;

  always #5 clk_int = ~clk_int;

  logic        clk_a, en_l_a;
  logic [15:0] cnt_a;
  logic        clk_b, en_l_b;
  logic [2:0]  cnt_b;

  clk_gate_ctrl #(.CntWidth(16), .ResetGate(1)) dut_a (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .test_en_i    (test_en_i),
    .clr_cnt_i    (clr_cnt_i),
    .clk_o        (clk_a),
    .en_latched_o (en_l_a),
    .cnt_o        (cnt_a)
  );

  clk_gate_ctrl #(.CntWidth(3), .ResetGate(0)) dut_b (
    .clk_int      (clk_int),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .test_en_i    (test_en_i),
    .clr_cnt_i    (clr_cnt_i),
    .clk_o        (clk_b),
    .en_latched_o (en_l_b),
    .cnt_o        (cnt_b)
  );

  // Count rising edges of the gated clock from dut_a.
  int pulses_a = 0;
  always @(posedge clk_a) pulses_a = pulses_a + 1;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected counter value: the counter is absent when the macro is undefined.
  function automatic logic [31:0] exp_cnt(input int v, input int width);
    int sat;
    sat = (1 << width) - 1;
`ifdef CLK_GATE_CNT_EN
    return (v > sat) ? sat : v;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_low();
    @(negedge clk_int);
    #1;
  endtask

  task automatic wait_high();
    @(posedge clk_int);
    #2;
  endtask

  // ---------------- directed sequence ----------------
  int p0;

  initial begin
    rst_ni    = 1'b0;
    en_i      = 1'b1;
    test_en_i = 1'b0;
    clr_cnt_i = 1'b0;

    // Reset with en_i=1: both gates must stay closed and the counters at zero.
    for (int i = 0; i < 3; i++) begin
      wait_high();
      check("rst_clk_a", clk_a, 0);
      check("rst_en_l_a", en_l_a, 0);
      check("rst_cnt_a", cnt_a, 0);
      check("rst_clk_b", clk_b, 0);
    end

    // Release reset in a low phase with en_i=0: the gate must stay closed.
    wait_low();
    rst_ni = 1'b1;
    en_i   = 1'b0;
    wait_high();
    check("idle_clk_a", clk_a, 0);

    // Basic gating: enable for exactly 4 high phases.
    wait_low();
    p0   = pulses_a;
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_high();
      check("basic_hi", clk_a, 1);
      wait_low();
      check("basic_lo", clk_a, 0);
    end
    en_i = 1'b0;
    wait_high();
    check("basic_off", clk_a, 0);
    check("basic_pulses", pulses_a - p0, 4);
    check("basic_cnt_a", cnt_a, exp_cnt(4, 16));

    // Glitch: toggle en_i 1->0->1 inside one high phase while the latch holds 1.
    wait_low();
    en_i = 1'b1;
    @(posedge clk_int);
    #1 en_i = 1'b0;
    #1 check("glitch_mid", clk_a, 1);
    #1 en_i = 1'b1;
    #1 check("glitch_late", clk_a, 1);
    check("glitch_en_l", en_l_a, 1);
    // Drop en_i during a high phase: this pulse completes, the next one is gated.
    @(posedge clk_int);
    #1 en_i = 1'b0;
    #3 check("drop_hold", clk_a, 1);
    wait_high();
    check("drop_next", clk_a, 0);
    check("glitch_cnt_a", cnt_a, exp_cnt(6, 16));

    // Counter: clear, then count 5 enabled cycles.
    wait_low();
    clr_cnt_i = 1'b1;
    wait_high();
    check("clr_cnt_a", cnt_a, 0);
    check("clr_cnt_b", cnt_b, 0);
    wait_low();
    clr_cnt_i = 1'b0;
    en_i      = 1'b1;
    for (int i = 0; i < 5; i++) wait_high();
    check("cnt5_a", cnt_a, exp_cnt(5, 16));
    check("cnt5_b", cnt_b, exp_cnt(5, 3));
    // A clear must win over a simultaneous increment.
    wait_low();
    clr_cnt_i = 1'b1;
    wait_high();
    check("clr_win_a", cnt_a, 0);
    check("clr_win_b", cnt_b, 0);
    wait_low();
    clr_cnt_i = 1'b0;
    wait_high();
    check("after_clr_a", cnt_a, exp_cnt(1, 16));
    // Saturation: dut_b (3 bits) must stop at 7.
    for (int i = 0; i < 10; i++) wait_high();
    check("sat_a", cnt_a, exp_cnt(11, 16));
    check("sat_b", cnt_b, exp_cnt(11, 3));
    wait_high();
    check("sat_hold_a", cnt_a, exp_cnt(12, 16));
    check("sat_hold_b", cnt_b, exp_cnt(12, 3));

    // Scan during reset: dut_a follows clk_int; dut_b (ResetGate=0) stays low.
    wait_low();
    en_i      = 1'b0;
    test_en_i = 1'b1;
    rst_ni    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_high();
      check("scan_hi_a", clk_a, 1);
      check("scan_b", clk_b, 0);
      wait_low();
      check("scan_lo_a", clk_a, 0);
    end
    check("scan_cnt_a", cnt_a, 0);

    // Leave scan mode while still in reset: reset takes priority over en_i again.
    test_en_i = 1'b0;
    en_i      = 1'b1;
    wait_high();
    check("rst_dom_clk_a", clk_a, 0);
    check("rst_dom_en_l_a", en_l_a, 0);
    // Release reset in the middle of a high phase: no partial pulse.
    #1 rst_ni = 1'b1;
    #1 check("rel_no_partial", clk_a, 0);
    wait_high();
    check("rel_next_a", clk_a, 1);
    check("rel_next_b", clk_b, 1);
    check("rel_cnt_a", cnt_a, exp_cnt(1, 16));
    // Assert reset while clk_o is high: the output must fall at once.
    #1 rst_ni = 1'b0;
    #1 check("rst_fall_a", clk_a, 0);
    check("rst_fall_en_l", en_l_a, 0);
    check("rst_fall_cnt", cnt_a, 0);
    check("rst_fall_b", clk_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
